// File: rtl/bodydrums_pkg.sv
// Shared bodydrums definitions: sequencer states, RAM read tag format and song-region defaults.
package bodydrums_pkg;

  localparam int unsigned SONG_SEL_W     = 4;
  localparam int unsigned SONG_SHIFT_DEF = 15;
  localparam int unsigned MEM_LAT_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic valid;
    logic is_gfx;
  } mem_tag_t;

  localparam int unsigned TAG_W = $bits(mem_tag_t);

endpackage

// File: rtl/song_mem_sequencer_if.sv
// Sequencer signal bundle: central FSM controls, audio sample stream, graphics reads and RAM port.
interface song_mem_sequencer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  import bodydrums_pkg::*;

  logic                  start_song;
  logic                  pause_song;
  logic                  record_mode;
  logic [SONG_SEL_W-1:0] song_choice;
  logic                  sample_tick;
  logic [DATA_W-1:0]     rec_sample;
  logic [DATA_W-1:0]     play_sample;
  logic                  play_valid;
  logic                  gfx_req;
  logic [ADDR_W-1:0]     gfx_addr;
  logic [DATA_W-1:0]     gfx_data;
  logic                  gfx_ack;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  song_done;

  // master is the surrounding system (FSM, codec, graphics, RAM); slave is the sequencer
  modport master (
    output start_song, pause_song, record_mode, song_choice, sample_tick, rec_sample,
           gfx_req, gfx_addr, mem_rdata,
    input  play_sample, play_valid, gfx_data, gfx_ack, mem_addr, mem_we, mem_wdata, song_done
  );

  modport slave (
    input  start_song, pause_song, record_mode, song_choice, sample_tick, rec_sample,
           gfx_req, gfx_addr, mem_rdata,
    output play_sample, play_valid, gfx_data, gfx_ack, mem_addr, mem_we, mem_wdata, song_done
  );

endinterface

// File: rtl/mem_tag_pipe.sv
// DEPTH-stage shift register of RAM read tags; the output stage marks a read whose data is on mem_rdata.
module mem_tag_pipe
  import bodydrums_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_LAT_DEF
) (
  input  logic     clk,
  input  logic     clr,
  input  mem_tag_t tag_in,
  output mem_tag_t tag_out
);

  mem_tag_t [DEPTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (clr) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/song_mem_sequencer.sv
// Shares one pipelined sample-RAM port between the audio stream (one access per sample tick)
// and graphics waveform reads, tracking song position within the selected region.
module song_mem_sequencer
  import bodydrums_pkg::*;
#(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SONG_SHIFT = SONG_SHIFT_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF
) (
  input logic                 clk,
  input logic                 reset,
  song_mem_sequencer_if.slave bus
);

  seq_state_e            state;
  seq_state_e            state_d;
  logic                  mode;
  logic [SONG_SEL_W-1:0] base;
  logic [SONG_SHIFT-1:0] offset;
  logic                  aud_pend;
  logic                  gfx_busy;
  logic                  iss_rd;
  logic                  iss_gfx;
  logic                  take_audio;
  logic                  take_gfx;
  logic                  last_sample;
  mem_tag_t              issue_tag;
  mem_tag_t              done_tag;

  assign last_sample = &offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // aud_pend marks the cycle the accepted sample is on the bus, so a tick during it is an overrun
  always_comb begin
    state_d    = state;
    take_audio = 1'b0;
    if (bus.start_song) begin
      state_d = bus.pause_song ? PAUSED : RUN;
    end else begin
      case (state)
        RUN: begin
          if (bus.pause_song) begin
            state_d = PAUSED;
          end else if (bus.sample_tick && !aud_pend) begin
            take_audio = 1'b1;
            if (last_sample) state_d = DONE;
          end
        end
        PAUSED: begin
          if (!bus.pause_song) state_d = RUN;
        end
        default: begin
        end
      endcase
    end
    // no re-issue in the ack cycle: the requester may still be holding gfx_req then
    take_gfx = !take_audio && bus.gfx_req && !gfx_busy && !bus.gfx_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode            <= 1'b0;
      base            <= '0;
      offset          <= '0;
      aud_pend        <= 1'b0;
      gfx_busy        <= 1'b0;
      iss_rd          <= 1'b0;
      iss_gfx         <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_wdata   <= '0;
      bus.play_sample <= '0;
      bus.play_valid  <= 1'b0;
      bus.gfx_data    <= '0;
      bus.gfx_ack     <= 1'b0;
      bus.song_done   <= 1'b0;
    end else begin
      aud_pend       <= take_audio;
      iss_rd         <= 1'b0;
      iss_gfx        <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.play_valid <= 1'b0;
      bus.gfx_ack    <= 1'b0;

      if (bus.start_song) begin
        mode          <= bus.record_mode;
        base          <= bus.song_choice;
        offset        <= '0;
        bus.song_done <= 1'b0;
      end

      if (done_tag.valid) begin
        if (done_tag.is_gfx) begin
          bus.gfx_data <= DATA_W'(bus.mem_rdata);
          bus.gfx_ack  <= 1'b1;
          gfx_busy     <= 1'b0;
        end else begin
          bus.play_sample <= DATA_W'(bus.mem_rdata);
          bus.play_valid  <= 1'b1;
        end
      end

      if (take_audio) begin
        bus.mem_addr  <= ADDR_W'({base, offset});
        bus.mem_we    <= mode;
        bus.mem_wdata <= DATA_W'(bus.rec_sample);
        offset        <= offset + SONG_SHIFT'(1);
        iss_rd        <= !mode;
        if (last_sample) bus.song_done <= 1'b1;
      end else if (take_gfx) begin
        bus.mem_addr <= bus.gfx_addr;
        iss_rd       <= 1'b1;
        iss_gfx      <= 1'b1;
        gfx_busy     <= 1'b1;
      end
    end
  end

  assign issue_tag = '{valid: iss_rd, is_gfx: iss_gfx};

  mem_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (reset),
    .tag_in  (issue_tag),
    .tag_out (done_tag)
  );

endmodule

// File: tb/tb_song_mem_sequencer.sv
// Directed bench for song_mem_sequencer: a long-region instance and a 16-sample-region instance,
// each with a MEM_LAT-latency RAM model.
module tb_song_mem_sequencer;

  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned MEM_LAT     = 2;
  localparam int unsigned SHORT_SHIFT = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  song_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b0 ();
  song_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();

  song_mem_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SONG_SHIFT(15), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );

  song_mem_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SONG_SHIFT(SHORT_SHIFT), .MEM_LAT(MEM_LAT)
  ) dut_short (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  // RAM model: fixed preload pattern overlaid by whatever the DUT writes
  logic [DATA_W-1:0] wr0 [int];
  logic [DATA_W-1:0] wr1 [int];
  logic [DATA_W-1:0] rp0 [MEM_LAT];
  logic [DATA_W-1:0] rp1 [MEM_LAT];

  function automatic logic [DATA_W-1:0] preset(int a);
    case (a)
      32'h18000: return 8'hA5;
      32'h00040: return 8'h3C;
      32'h0001F: return 8'h7E;
      default:   return 8'(a) ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] peek0(int a);
    return wr0.exists(a) ? wr0[a] : preset(a);
  endfunction

  function automatic logic [DATA_W-1:0] peek1(int a);
    return wr1.exists(a) ? wr1[a] : preset(a);
  endfunction

  always @(posedge clk) begin
    rp0[0] <= peek0(int'(b0.mem_addr));
    rp1[0] <= peek1(int'(b1.mem_addr));
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      rp0[i] <= rp0[i-1];
      rp1[i] <= rp1[i-1];
    end
    if (b0.mem_we) wr0[int'(b0.mem_addr)] = b0.mem_wdata;
    if (b1.mem_we) wr1[int'(b1.mem_addr)] = b1.mem_wdata;
  end

  assign b0.mem_rdata = rp0[MEM_LAT-1];
  assign b1.mem_rdata = rp1[MEM_LAT-1];

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    b0.start_song = 1'b0; b0.pause_song = 1'b0; b0.record_mode = 1'b0; b0.song_choice = '0;
    b0.sample_tick = 1'b0; b0.rec_sample = '0; b0.gfx_req = 1'b0; b0.gfx_addr = '0;
    b1.start_song = 1'b0; b1.pause_song = 1'b0; b1.record_mode = 1'b0; b1.song_choice = '0;
    b1.sample_tick = 1'b0; b1.rec_sample = '0; b1.gfx_req = 1'b0; b1.gfx_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    checks++;
    if (b0.mem_addr !== '0) $display("FAIL reset_mem_addr: got %0h want 0", b0.mem_addr);
    else passed++;
    checks++;
    if ({b0.mem_we, b0.play_valid, b0.gfx_ack, b0.song_done} !== 4'b0)
      $display("FAIL reset_flags: got we/pv/ack/done=%b want 0000",
               {b0.mem_we, b0.play_valid, b0.gfx_ack, b0.song_done});
    else passed++;
    checks++;
    if (b0.mem_wdata !== '0) $display("FAIL reset_mem_wdata: got %0h want 0", b0.mem_wdata);
    else passed++;
    checks++;
    if (b0.play_sample !== '0) $display("FAIL reset_play_sample: got %0h want 0", b0.play_sample);
    else passed++;
    checks++;
    if (b0.gfx_data !== '0) $display("FAIL reset_gfx_data: got %0h want 0", b0.gfx_data);
    else passed++;
    checks++;
    if (b1.song_done !== 1'b0) $display("FAIL reset_short_done: got %b want 0", b1.song_done);
    else passed++;
  endtask

  task automatic test_playback();
    b0.song_choice = 4'd3; b0.record_mode = 1'b0; b0.pause_song = 1'b0; b0.start_song = 1'b1;
    step(1);
    b0.start_song = 1'b0;
    step(9);
    b0.sample_tick = 1'b1;
    step(1);
    b0.sample_tick = 1'b0;
    checks++;
    if (b0.mem_addr !== 19'h18000 || b0.mem_we !== 1'b0)
      $display("FAIL play_issue: got addr=%0h we=%b want addr=18000 we=0", b0.mem_addr, b0.mem_we);
    else passed++;
    step(2);
    checks++;
    if (b0.play_valid !== 1'b0) $display("FAIL play_not_early: got play_valid=%b want 0", b0.play_valid);
    else passed++;
    step(1);
    checks++;
    if (b0.play_valid !== 1'b1 || b0.play_sample !== 8'hA5)
      $display("FAIL play_data: got pv=%b sample=%0h want pv=1 sample=a5", b0.play_valid, b0.play_sample);
    else passed++;
  endtask

  task automatic test_record();
    logic [7:0] vals [3];
    int pv;
    vals = '{8'h11, 8'h22, 8'h33};
    pv = 0;
    b0.song_choice = 4'd0; b0.record_mode = 1'b1; b0.start_song = 1'b1;
    step(1);
    b0.start_song = 1'b0; b0.record_mode = 1'b0;
    step(1);
    for (int k = 0; k < 3; k++) begin
      b0.sample_tick = 1'b1; b0.rec_sample = vals[k];
      step(1);
      b0.sample_tick = 1'b0; b0.rec_sample = 8'hEE;
      if (b0.play_valid) pv++;
      checks++;
      if (b0.mem_we !== 1'b1 || b0.mem_addr !== 19'(k) || b0.mem_wdata !== vals[k])
        $display("FAIL record_write%0d: got we=%b addr=%0h data=%0h want we=1 addr=%0h data=%0h",
                 k, b0.mem_we, b0.mem_addr, b0.mem_wdata, k, vals[k]);
      else passed++;
      step(1);
      if (b0.play_valid) pv++;
    end
    for (int n = 0; n < 4; n++) begin
      step(1);
      if (b0.play_valid) pv++;
    end
    checks++;
    if (pv !== 0) $display("FAIL record_no_play: got %0d play_valid pulses want 0", pv);
    else passed++;
  endtask

  task automatic test_collision();
    int acks, ack_at, play_at;
    logic [7:0] gdata, pdata;
    acks = 0; ack_at = -1; play_at = -1; gdata = '0; pdata = '0;
    b0.song_choice = 4'd0; b0.record_mode = 1'b0; b0.start_song = 1'b1;
    step(1);
    b0.start_song = 1'b0;
    step(2);
    b0.sample_tick = 1'b1; b0.gfx_req = 1'b1; b0.gfx_addr = 19'h40;
    step(1);
    b0.sample_tick = 1'b0;
    checks++;
    if (b0.mem_addr !== 19'h0 || b0.mem_we !== 1'b0)
      $display("FAIL collision_audio_first: got addr=%0h we=%b want addr=0 we=0", b0.mem_addr, b0.mem_we);
    else passed++;
    step(1);
    checks++;
    if (b0.mem_addr !== 19'h40) $display("FAIL collision_gfx_next: got addr=%0h want 40", b0.mem_addr);
    else passed++;
    for (int n = 3; n <= 12; n++) begin
      step(1);
      if (b0.play_valid && play_at < 0) begin
        play_at = n; pdata = b0.play_sample;
      end
      if (b0.gfx_ack) begin
        acks++;
        if (ack_at < 0) ack_at = n;
        gdata = b0.gfx_data;
        b0.gfx_req = 1'b0;
      end
    end
    b0.gfx_req = 1'b0;
    checks++;
    if (play_at !== 4 || pdata !== 8'h11)
      $display("FAIL collision_play: got cycle=%0d data=%0h want cycle=4 data=11", play_at, pdata);
    else passed++;
    checks++;
    if (ack_at !== 5) $display("FAIL collision_ack_latency: got cycle=%0d want 5", ack_at);
    else passed++;
    checks++;
    if (acks !== 1) $display("FAIL collision_single_ack: got %0d acks want 1", acks);
    else passed++;
    checks++;
    if (gdata !== 8'h3C) $display("FAIL collision_gfx_data: got %0h want 3c", gdata);
    else passed++;
  endtask

  task automatic test_pause();
    int bad;
    logic [7:0] gdata;
    logic got;
    bad = 0; gdata = '0; got = 1'b0;
    b0.song_choice = 4'd2; b0.record_mode = 1'b0; b0.start_song = 1'b1;
    step(1);
    b0.start_song = 1'b0;
    step(1);
    for (int k = 0; k < 5; k++) begin
      b0.sample_tick = 1'b1;
      step(1);
      b0.sample_tick = 1'b0;
      step(1);
    end
    b0.pause_song = 1'b1;
    step(1);
    for (int k = 0; k < 20; k++) begin
      b0.sample_tick = 1'b1;
      step(1);
      b0.sample_tick = 1'b0;
      if (b0.mem_we || b0.mem_addr !== 19'h10004) bad++;
      step(1);
      if (b0.mem_we || b0.mem_addr !== 19'h10004) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL pause_no_access: got %0d bus changes want 0", bad);
    else passed++;
    b0.gfx_req = 1'b1; b0.gfx_addr = 19'h1;
    for (int n = 0; n < 10; n++) begin
      step(1);
      if (b0.gfx_ack) begin
        gdata = b0.gfx_data; got = 1'b1; b0.gfx_req = 1'b0;
        break;
      end
    end
    b0.gfx_req = 1'b0;
    checks++;
    if (got !== 1'b1 || gdata !== 8'h22)
      $display("FAIL pause_gfx_served: got ack=%b data=%0h want ack=1 data=22", got, gdata);
    else passed++;
    b0.pause_song = 1'b0;
    step(1);
    b0.sample_tick = 1'b1;
    step(1);
    b0.sample_tick = 1'b0;
    checks++;
    if (b0.mem_addr !== 19'h10005) $display("FAIL pause_resume_addr: got %0h want 10005", b0.mem_addr);
    else passed++;
  endtask

  task automatic test_end_of_region();
    int early;
    early = 0;
    b1.song_choice = 4'd1; b1.record_mode = 1'b0; b1.start_song = 1'b1;
    step(1);
    b1.start_song = 1'b0;
    step(1);
    for (int k = 0; k < 16; k++) begin
      b1.sample_tick = 1'b1;
      step(1);
      b1.sample_tick = 1'b0;
      if (k < 15 && b1.song_done) early++;
      if (k == 15) begin
        checks++;
        if (b1.song_done !== 1'b1 || b1.mem_addr !== 19'h1F)
          $display("FAIL eor_last_issue: got done=%b addr=%0h want done=1 addr=1f", b1.song_done, b1.mem_addr);
        else passed++;
      end
      step(1);
    end
    checks++;
    if (early !== 0) $display("FAIL eor_done_early: got %0d early cycles want 0", early);
    else passed++;
    b1.sample_tick = 1'b1;
    step(1);
    b1.sample_tick = 1'b0;
    checks++;
    if (b1.mem_addr !== 19'h1F || b1.mem_we !== 1'b0 || b1.song_done !== 1'b1)
      $display("FAIL eor_tick_ignored: got addr=%0h we=%b done=%b want addr=1f we=0 done=1",
               b1.mem_addr, b1.mem_we, b1.song_done);
    else passed++;
    step(1);
    checks++;
    if (b1.play_valid !== 1'b1 || b1.play_sample !== 8'h7E)
      $display("FAIL eor_last_data: got pv=%b sample=%0h want pv=1 sample=7e", b1.play_valid, b1.play_sample);
    else passed++;
    b1.start_song = 1'b1;
    step(1);
    b1.start_song = 1'b0;
    checks++;
    if (b1.song_done !== 1'b0) $display("FAIL eor_restart_clears: got done=%b want 0", b1.song_done);
    else passed++;
    b1.sample_tick = 1'b1;
    step(1);
    b1.sample_tick = 1'b0;
    checks++;
    if (b1.mem_addr !== 19'h10) $display("FAIL eor_restart_offset0: got %0h want 10", b1.mem_addr);
    else passed++;
  endtask

  task automatic test_disruption();
    int pv;
    pv = 0;
    b0.song_choice = 4'd3; b0.record_mode = 1'b0; b0.start_song = 1'b1;
    step(1);
    b0.start_song = 1'b0;
    step(1);
    for (int k = 0; k < 2; k++) begin
      b0.sample_tick = 1'b1;
      step(1);
      b0.sample_tick = 1'b0;
      step(1);
    end
    b0.start_song = 1'b1; b0.sample_tick = 1'b1;
    step(1);
    b0.start_song = 1'b0; b0.sample_tick = 1'b0;
    checks++;
    if (b0.mem_we !== 1'b0 || b0.mem_addr !== 19'h18001)
      $display("FAIL start_drops_tick: got addr=%0h we=%b want addr=18001 we=0", b0.mem_addr, b0.mem_we);
    else passed++;
    b0.sample_tick = 1'b1;
    step(1);
    b0.sample_tick = 1'b0;
    checks++;
    if (b0.mem_addr !== 19'h18000) $display("FAIL start_offset0: got %0h want 18000", b0.mem_addr);
    else passed++;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (b0.mem_addr !== '0) $display("FAIL reset_mid_song_addr: got %0h want 0", b0.mem_addr);
    else passed++;
    for (int n = 0; n < 6; n++) begin
      if (b0.play_valid) pv++;
      step(1);
    end
    checks++;
    if (pv !== 0) $display("FAIL reset_drops_inflight: got %0d play_valid pulses want 0", pv);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_playback();
    test_record();
    test_collision();
    test_pause();
    test_end_of_region();
    test_disruption();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/song_mem_sequencer.md
Name: song_mem_sequencer

Overview:
- Sequences the shared single-port sample RAM for the bodydrums system.
- Driven by the central FSM signals start_song, pause_song, record_mode and song_choice; returns song_done to it.
- On each audio sample tick it issues one playback read or one record write to the selected song's region.
- Interleaves graphics waveform reads on idle cycles; one read requester and the audio stream share one pipelined RAM port.

Parameters:
- ADDR_W, 19, RAM address width; must be ≥ 4 + SONG_SHIFT.
- DATA_W, 8, sample width.
- SONG_SHIFT, 15, log2 of samples per song region; region base = song_choice << SONG_SHIFT.
- MEM_LAT, 2, RAM read latency in cycles (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_song  in  1  one-cycle pulse from the central FSM; begins a song.
- pause_song  in  1  level; 1 = hold position.
- record_mode  in  1  sampled on start_song; 1 = write, 0 = read.
- song_choice  in  4  region index, sampled on start_song.
- sample_tick  in  1  one-cycle audio-rate strobe.
- rec_sample  in  DATA_W  sample to record, valid with sample_tick.
- play_sample  out  DATA_W  last played sample.
- play_valid  out  1  one-cycle pulse when play_sample updates.
- gfx_req  in  1  graphics read request; held until gfx_ack.
- gfx_addr  in  ADDR_W  graphics read address, stable while gfx_req.
- gfx_data  out  DATA_W  graphics read data.
- gfx_ack  out  1  one-cycle pulse, gfx_data valid.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after a read issue.
- song_done  out  1  level; end of region reached.

Behaviour:
- **Reset values:** every output is 0. State = IDLE; offset = 0; pending flags and the tag pipe are cleared. A reset mid-song discards in-flight reads: no play_valid or gfx_ack is produced for them.
- **States:** IDLE, RUN, PAUSED, DONE.
  - Any state, start_song=1: latch mode and base, set offset = 0, clear song_done and audio pending. Go to RUN if pause_song=0, otherwise PAUSED. start_song has priority over every other event in the same cycle; a coincident sample_tick is dropped.
  - RUN, pause_song=1: go to PAUSED and clear audio pending.
  - PAUSED, pause_song=0: go to RUN. Ticks seen while PAUSED, IDLE or DONE are ignored.
  - RUN, sample_tick: set audio pending. A tick arriving while pending is already set is dropped (overrun; no error reported).
- **Issue slot (one access per cycle, pipelined):**
  - Audio pending has priority. Drive mem_addr = base + offset. mem_we = record_mode. mem_wdata = the rec_sample latched at the tick.
  - Clear pending and increment offset in the same cycle.
  - Audio is issued the cycle after the tick.
  - If no audio issue, gfx_req=1 and no graphics read outstanding: issue a read at gfx_addr and set gfx_busy.
  - Otherwise mem_we = 0 and mem_addr holds its previous value.
- **Tag pipe:** MEM_LAT deep, entries {valid, is_gfx}.
  - Matured audio read: register mem_rdata into play_sample and pulse play_valid.
  - Matured graphics read: register into gfx_data, pulse gfx_ack and clear gfx_busy. gfx_ack therefore comes MEM_LAT+1 cycles after issue.
  - Writes insert no tag.
- **End of region:** the access issued at offset = 2^SONG_SHIFT−1 completes normally, with its read data still delivered. That cycle the block goes to DONE and sets song_done=1. song_done holds until the next start_song or reset.
- **Graphics in DONE/IDLE/PAUSED:** graphics reads are served in every state.
- **Widths:** offset is SONG_SHIFT bits. Address = {song_choice, offset} zero-extended to ADDR_W; there is no wrap into the adjacent region.

Decomposition:
- Shared package (bodydrums_pkg) holds:
  - state enum (IDLE=0, RUN=1, PAUSED=2, DONE=3);
  - tag field widths;
  - default SONG_SHIFT and MEM_LAT constants, also used by the central FSM's song-number mapping.
- One sub-module: mem_tag_pipe, a MEM_LAT-stage shift register of {valid, is_gfx} with synchronous clear.

Test Plan:
- **Playback start:** reset; start_song with song_choice=3, record_mode=0, pause_song=0; tick at cycle 10 → mem_addr=0x18000, mem_we=0 at cycle 11. play_valid at cycle 11+MEM_LAT+1 with the preloaded value 0xA5.
- **Record:** record_mode=1, song_choice=0; ticks carrying 0x11, 0x22, 0x33 → writes to addresses 0, 1, 2 with matching mem_wdata; no play_valid.
- **Collision:** sample_tick and gfx_req (addr 0x40) in the same cycle → audio issued first, graphics the next cycle. gfx_ack carries RAM[0x40]; gfx_ack never pulses twice for one request.
- **Pause:** pause after 5 samples; 20 ticks while paused → no RAM access. Unpause then tick → address = base+5.
- **End of region (SONG_SHIFT=4):** 16 ticks → song_done rises in the cycle of the 16th issue, and the 17th tick is ignored. A new start_song clears song_done and restarts at offset 0.
- **Disruption mid-read:** reset with a read in flight → no play_valid afterwards. Separately, start_song coincident with a tick → no access that cycle and offset=0.
